// File: rtl/note_sequencer_pkg.sv
// rtl/note_sequencer_pkg.sv - shared constants and state encoding for the note sequencer
// Purpose: state encoding, note-entry field offsets and the half-period width
//          shared between the sequencer, its note table and the synth.
// Ports:   none (package).
package note_sequencer_pkg;

  // Half-period width shared with the square-wave synth.
  localparam int HP_W      = 7;

  // Note entry layout: {last, dur, hp}.
  localparam int HP_LSB    = 0;
  localparam int DUR_LSB   = 7;
  localparam int DUR_W_DEF = 4;
  localparam int LAST_BIT  = DUR_LSB + DUR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - control/status bundle between config logic and the note sequencer
// Purpose: groups the table write port, playback controls and synth/status
//          outputs of note_sequencer.
// Modports: master - config logic (drives writes/controls, reads status)
//           slave  - note_sequencer
interface note_sequencer_if #(
  parameter int DEPTH   = 16,
  parameter int DUR_W   = 4,
  parameter int TEMPO_W = 16
);
  import note_sequencer_pkg::*;

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + DUR_W + HP_W;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic               start;
  logic               stop;
  logic               loop_en;
  logic [TEMPO_W-1:0] tempo;
  logic [HP_W-1:0]    hp;
  logic               active;
  logic               busy;
  logic [IDX_W-1:0]   note_idx;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_en, tempo,
    input  hp, active, busy, note_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_en, tempo,
    output hp, active, busy, note_idx, done
  );

endinterface

// File: rtl/note_sequencer_note_table.sv
// rtl/note_sequencer_note_table.sv - DEPTH x entry register file for the melody table
// Purpose: one synchronous write port, one combinational read port,
//          synchronous clear of every entry on i_rst.
// Ports:   i_clk, i_rst (sync, active-high), i_wr_en/i_wr_addr/i_wr_data write port,
//          i_rd_addr -> o_rd_data combinational read.
module note_table #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 12,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]   i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read is from the registered contents, so a same-cycle write is not visible.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - plays a programmable note table on the square-wave synth
// Purpose: steps through a DEPTH-entry {last, dur, hp} table at a programmable
//          tempo, driving the synth half-period and enable; loops or finishes.
// Ports:   synth_clk, rst (sync, active-high), bus (note_sequencer_if.slave):
//          table write, start/stop/loop_en/tempo in; hp/active/busy/note_idx/done out.
// Option:  NOTE_SEQ_LEGATO_EN - hold hp/active through LOAD (no retrigger gap).
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DUR_W   = 4,
  parameter int TEMPO_W = 16
) (
  input  logic              synth_clk,
  input  logic              rst,
  note_sequencer_if.slave   bus
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + DUR_W + HP_W;
  localparam int LAST_B  = DUR_LSB + DUR_W;

  state_t             r_state, w_state_nx;
  logic [HP_W-1:0]    r_hp, w_hp_nx;
  logic               r_active, w_active_nx;
  logic               r_busy;
  logic [IDX_W-1:0]   r_idx, w_idx_nx;
  logic               r_done, w_done_nx;
  logic [TEMPO_W-1:0] r_tempo, w_tempo_nx;
  logic [TEMPO_W-1:0] r_beat, w_beat_nx;
  logic [DUR_W-1:0]   r_dur_cnt, w_dur_cnt_nx;
  logic [DUR_W-1:0]   r_dur, w_dur_nx;
  logic               r_last, w_last_nx;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_note_end;
  logic               w_hold_active;

  note_table #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .IDX_W   (IDX_W)
  ) u_note_table (
    .i_clk     (synth_clk),
    .i_rst     (rst),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_entry)
  );

  // Last beat of the last beat-group of the note.
  assign w_note_end = (r_beat == r_tempo) && (r_dur_cnt == r_dur);

`ifdef NOTE_SEQ_LEGATO_EN
  assign w_hold_active = r_active;
`else
  assign w_hold_active = 1'b0;
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_hp_nx      = r_hp;
    w_active_nx  = r_active;
    w_idx_nx     = r_idx;
    w_done_nx    = 1'b0;
    w_tempo_nx   = r_tempo;
    w_beat_nx    = r_beat;
    w_dur_cnt_nx = r_dur_cnt;
    w_dur_nx     = r_dur;
    w_last_nx    = r_last;
    case (r_state)
      ST_IDLE: begin
        w_active_nx = 1'b0;
        if (bus.start && !bus.stop) begin
          w_state_nx = ST_LOAD;
          w_idx_nx   = '0;
        end
      end
      ST_LOAD: begin
        if (bus.stop) begin
          w_state_nx  = ST_IDLE;
          w_active_nx = 1'b0;
        end else begin
          w_state_nx   = ST_PLAY;
          w_hp_nx      = w_entry[HP_LSB +: HP_W];
          w_active_nx  = (w_entry[HP_LSB +: HP_W] != '0);
          w_dur_nx     = w_entry[DUR_LSB +: DUR_W];
          w_last_nx    = w_entry[LAST_B];
          w_tempo_nx   = (bus.tempo == '0) ? TEMPO_W'(1) : bus.tempo;
          w_beat_nx    = TEMPO_W'(1);
          w_dur_cnt_nx = '0;
        end
      end
      ST_PLAY: begin
        if (bus.stop) begin
          w_state_nx  = ST_IDLE;
          w_active_nx = 1'b0;
        end else if (w_note_end) begin
          if (!r_last) begin
            w_state_nx  = ST_LOAD;
            w_idx_nx    = r_idx + 1'b1;
            w_active_nx = w_hold_active;
          end else if (bus.loop_en) begin
            w_state_nx  = ST_LOAD;
            w_idx_nx    = '0;
            w_active_nx = w_hold_active;
          end else begin
            w_state_nx  = ST_IDLE;
            w_active_nx = 1'b0;
            w_done_nx   = 1'b1;
          end
        end else if (r_beat == r_tempo) begin
          w_beat_nx    = TEMPO_W'(1);
          w_dur_cnt_nx = r_dur_cnt + 1'b1;
        end else begin
          w_beat_nx = r_beat + 1'b1;
        end
      end
      default: begin
        w_state_nx  = ST_IDLE;
        w_active_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge synth_clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hp      <= '0;
      r_active  <= 1'b0;
      r_busy    <= 1'b0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_tempo   <= '0;
      r_beat    <= '0;
      r_dur_cnt <= '0;
      r_dur     <= '0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_hp      <= w_hp_nx;
      r_active  <= w_active_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
      r_idx     <= w_idx_nx;
      r_done    <= w_done_nx;
      r_tempo   <= w_tempo_nx;
      r_beat    <= w_beat_nx;
      r_dur_cnt <= w_dur_cnt_nx;
      r_dur     <= w_dur_nx;
      r_last    <= w_last_nx;
    end
  end

  assign bus.hp       = r_hp;
  assign bus.active   = r_active;
  assign bus.busy     = r_busy;
  assign bus.note_idx = r_idx;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer
module tb_note_sequencer;
  import note_sequencer_pkg::*;

  typedef struct packed {
    logic       done;
    logic       busy;
    logic [3:0] idx;
    logic       active;
    logic [6:0] hp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_sequencer_if #(.DEPTH(16), .DUR_W(4), .TEMPO_W(16)) bus ();

  note_sequencer #(.DEPTH(16), .DUR_W(4), .TEMPO_W(16)) dut (
    .synth_clk (clk),
    .rst       (rst),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        exp_q[$];
  logic [11:0] tab[16];
  logic [6:0]  g_hp = '0;
  bit          g_loop = 1'b0;
  int          loop_off_at = 1 << 30;
  int          stop_item = -1;
  int          start_at = -1;
  int          wr_at = -1;
  logic [3:0]  wr_a = '0;
  logic [11:0] wr_d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic b, input logic [3:0] i,
                              input logic a, input logic [6:0] h);
    exp_t e;
    e.done = d; e.busy = b; e.idx = i; e.active = a; e.hp = h;
    return e;
  endfunction

  function automatic exp_t observe();
    return mk(bus.done, bus.busy, bus.note_idx, bus.active, bus.hp);
  endfunction

  // Expected per-cycle outputs from the cycle after start, derived from the
  // note table: LOAD (1 cycle), (dur+1)*tempo PLAY cycles per note, done pulse.
  task automatic gen(input int tempo_v);
    int          t;
    int          n;
    int          reps;
    logic [3:0]  idx;
    logic [11:0] e;
    logic [6:0]  hp_h;
    logic        act_h;
    logic        load_act;
    exp_t        last_e;
    t = (tempo_v == 0) ? 1 : tempo_v;
    exp_q.delete();
    idx = '0; hp_h = g_hp; act_h = 1'b0; n = 0;
    exp_q.push_back(mk(1'b0, 1'b1, idx, 1'b0, hp_h)); n++;
    while (n < 600) begin
      e = (wr_at >= 0 && (n - 1) > wr_at && idx == wr_a) ? wr_d : tab[idx];
      hp_h = e[6:0]; act_h = (hp_h != '0);
      reps = (int'(e[10:7]) + 1) * t;
      for (int k = 0; k < reps; k++) begin
        exp_q.push_back(mk(1'b0, 1'b1, idx, act_h, hp_h)); n++;
      end
`ifdef NOTE_SEQ_LEGATO_EN
      load_act = act_h;
`else
      load_act = 1'b0;
`endif
      if (!e[11]) begin
        idx++;
        exp_q.push_back(mk(1'b0, 1'b1, idx, load_act, hp_h)); n++;
      end else if (g_loop && (n - 1) < loop_off_at) begin
        idx = '0;
        exp_q.push_back(mk(1'b0, 1'b1, idx, load_act, hp_h)); n++;
      end else begin
        exp_q.push_back(mk(1'b1, 1'b0, idx, 1'b0, hp_h));
        exp_q.push_back(mk(1'b0, 1'b0, idx, 1'b0, hp_h));
        break;
      end
    end
    if (stop_item >= 0) begin
      while (exp_q.size() > stop_item + 1) void'(exp_q.pop_back());
      last_e = exp_q[exp_q.size() - 1];
      exp_q.push_back(mk(1'b0, 1'b0, last_e.idx, 1'b0, last_e.hp));
    end
    last_e = exp_q[exp_q.size() - 1];
    g_hp = last_e.hp;
  endtask

  task automatic run(input string name, input int tempo_v);
    int   i;
    exp_t ex;
    gen(tempo_v);
    bus.tempo   = 16'(tempo_v);
    bus.loop_en = g_loop;
    @(negedge clk);
    bus.start = 1'b1;
    i = 0;
    while (exp_q.size() > 0 && i < 2000) begin
      @(negedge clk);
      ex = exp_q.pop_front();
      check($sformatf("%s_c%0d", name, i), 32'(observe()), 32'(ex));
      bus.start   = (i == start_at);
      bus.stop    = (i == stop_item);
      bus.loop_en = g_loop && (i < loop_off_at);
      bus.wr_en   = (i == wr_at);
      bus.wr_addr = wr_a;
      bus.wr_data = wr_d;
      i++;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0; bus.wr_en = 1'b0; bus.loop_en = 1'b0;
    if (wr_at >= 0) tab[wr_a] = wr_d;
    g_loop = 1'b0; loop_off_at = 1 << 30; stop_item = -1; start_at = -1; wr_at = -1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    tab[a] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) tab[i] = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.tempo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out", 32'(observe()), 32'(0));

    // Single note: 12 active cycles then done.
    wr(4'd0, {1'b1, 4'd2, 7'd10});
    run("single", 4);

    // Sequence with a rest.
    wr(4'd0, {1'b0, 4'd0, 7'd20});
    wr(4'd1, {1'b0, 4'd1, 7'd0});
    wr(4'd2, {1'b1, 4'd0, 7'd30});
    run("rest", 3);

    // Loop forever (start while busy ignored), then stop.
    g_loop = 1'b1; stop_item = 40; start_at = 5;
    run("loop", 3);

    // Loop, then drop loop_en so the second pass finishes.
    g_loop = 1'b1; loop_off_at = 20;
    run("loopoff", 3);

    // Stop on the second PLAY cycle.
    wr(4'd0, {1'b0, 4'd3, 7'd50});
    stop_item = 2;
    run("stop", 2);

    // start and stop together stay idle.
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    check("startstop_busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    check("startstop_busy2", 32'(bus.busy), 32'(0));

    // tempo=0, one-cycle notes, index wraps 15 -> 0.
    for (int i = 0; i < 16; i++) wr(4'(i), {1'b0, 4'd0, 7'(i + 1)});
    stop_item = 40;
    run("wrap", 0);

    // Rewrite the playing entry: heard on the next visit only.
    wr(4'd0, {1'b0, 4'd1, 7'd11});
    wr(4'd1, {1'b1, 4'd0, 7'd12});
    g_loop = 1'b1; stop_item = 20; wr_at = 2; wr_a = 4'd0; wr_d = {1'b0, 4'd1, 7'd40};
    run("wrplay", 2);

    // Write in the same cycle as LOAD of that entry: LOAD sees old data.
    g_loop = 1'b1; stop_item = 25; wr_at = 8; wr_a = 4'd0; wr_d = {1'b0, 4'd1, 7'd55};
    run("wrload", 2);

    // Reset mid-play restores reset values and clears the table.
    @(negedge clk);
    bus.tempo = 16'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_out", 32'(observe()), 32'(0));
    for (int i = 0; i < 16; i++) tab[i] = '0;
    g_hp = '0;
    stop_item = 4;
    run("cleared", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Plays a programmable melody table on the square-wave synth by driving its half-period (hp) and active inputs.
- Runs on synth_clk. Holds a DEPTH-entry note table written by the top-level config logic.
- Steps through the table at a programmable tempo and signals completion or loops.

Parameters:
- DEPTH, 16: number of note-table entries (power of two); IDX_W = log2(DEPTH).
- DUR_W, 4: note duration field width; a note lasts dur+1 beats.
- TEMPO_W, 16: width of the tempo input (synth_clk cycles per beat).

Ports:
- synth_clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  note-table write strobe.
- wr_addr  in  IDX_W  table write address.
- wr_data  in  1+DUR_W+7  entry {last, dur, hp}.
- start  in  1  begin playback from entry 0. Single-cycle pulse, honoured only in IDLE.
- stop  in  1  abort playback. Single-cycle pulse, honoured in any state.
- loop_en  in  1  on a last entry, restart at entry 0 instead of finishing.
- tempo  in  TEMPO_W  cycles per beat; 0 is treated as 1.
- hp  out  7  half-period to the synth.
- active  out  1  synth enable.
- busy  out  1  high when not in IDLE.
- note_idx  out  IDX_W  index of the entry being loaded or played.
- done  out  1  one-cycle pulse when playback ends naturally.

Behaviour:
- Reset:
  - state=IDLE; hp=0, active=0, busy=0, note_idx=0, done=0.
  - All table entries cleared to 0.
  - Beat and duration counters cleared to 0.
- Table write:
  - Takes effect on the clock edge when wr_en=1; allowed in any state.
  - A write to the entry currently playing does not change the sounding note. It is used at that entry's next LOAD.
  - A write and a LOAD of the same address in the same cycle: LOAD sees the old data.
- States: IDLE, LOAD, PLAY. All outputs are registered.
- IDLE:
  - active=0. start=1 and stop=0 -> LOAD, note_idx=0.
- LOAD (exactly 1 cycle):
  - Latch the entry at note_idx and latch tempo (0->1).
  - active=0 (retriggers the synth phase). Next state is PLAY.
  - On entering PLAY: hp<=entry.hp; active<=(entry.hp!=0). hp==0 encodes a rest.
- PLAY:
  - Beat counter counts 1..tempo. At tempo it wraps to 1 and the duration counter increments.
  - The note ends after exactly (dur+1)*tempo cycles in PLAY.
  - On note end with last=0: note_idx<=note_idx+1, wrapping DEPTH-1 -> 0 whether or not last is set. Next state is LOAD.
  - On note end with last=1 and loop_en=1: note_idx<=0, next state is LOAD.
  - On note end with last=1 and loop_en=0: next state is IDLE, active<=0, done=1 for one cycle.
- Latency:
  - start sampled at edge T gives busy=1 after T and active (non-rest note) after T+1.
  - Note-to-note gap is 1 cycle of active=0.
- stop:
  - In LOAD or PLAY: next state is IDLE; active<=0 on the same edge; no done pulse; note_idx unchanged.
  - start and stop in the same cycle: stop wins.
  - start while busy is ignored.
- loop_en and hp are used only at the events above. tempo is sampled only in LOAD.
- rst in any state overrides everything and restores reset values on that edge.

Optional Feature:
- NOTE_SEQ_LEGATO_EN defined:
  - In LOAD, hp and active hold their PLAY values; there is no retrigger gap.
  - The next entry's hp/active are applied on entry to PLAY, so consecutive non-rest notes give a continuous active=1.
- Undefined: behaviour is as above (active=0 during LOAD).

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_LOAD, ST_PLAY;
  - the entry field offsets (HP_LSB=0, DUR_LSB=7, LAST_BIT=7+DUR_W);
  - the HP_W=7 constant shared with the synth.
- One sub-module, note_table: a DEPTH x entry register file with one synchronous write port, one combinational read port, and a synchronous clear on rst.

Test Plan:
- Single note:
  - Stimulus: write entry0={1,2,7'd10}, tempo=4, start.
  - Required: hp=10, active=1 for exactly 12 cycles; then done pulse, busy=0.
- Sequence with rest:
  - Stimulus: entries {0,0,20},{0,1,0},{1,0,30}, tempo=3.
  - Required: active pattern 3 cycles on, 1 cycle off, 6 cycles off (rest), 1 cycle off, 3 cycles on; then done.
- Loop:
  - Stimulus: same table with loop_en=1.
  - Required: note_idx sequence 0,1,2,0,1..., no done pulse. Deasserting loop_en mid-play ends playback at the next last entry.
- Stop mid-note:
  - Stimulus: stop on the 2nd PLAY cycle.
  - Required: active=0 and busy=0 on the next cycle, no done. start+stop together leaves the block in IDLE.
- tempo=0 and wrap:
  - Stimulus: tempo=0; all DEPTH entries with last=0, dur=0.
  - Required: each note lasts 1 cycle; note_idx wraps 15->0; playback continues until stop.
- Write during play and legato:
  - Stimulus: rewrite the playing entry.
  - Required: the sounding hp is unchanged; the new hp is heard on the next visit.
  - With NOTE_SEQ_LEGATO_EN: two adjacent notes give active=1 with no gap cycle.
